// File: rtl/data_memory_ctrl_if.sv
// Request/response bundle for data_memory_ctrl.
// master: CPU side (drives requests); slave: memory side.
interface data_memory_ctrl_if #(
  parameter int ADDR_WIDTH = 32
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] address;
  logic [31:0]           write_data;
  logic                  resp_valid;
  logic [31:0]           read_data;
  logic                  misaligned;
  logic                  busy;

  modport master (
    output req_valid, req_write, req_size,
    output req_unsigned, address, write_data,
    input  req_ready, resp_valid, read_data,
    input  misaligned, busy
  );

  modport slave (
    input  req_valid, req_write, req_size,
    input  req_unsigned, address, write_data,
    output req_ready, resp_valid, read_data,
    output misaligned, busy
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// Byte-addressable data memory with init sequencer and
// pipelined read path. Ports: clock_in, reset, bus m (slave).
module data_memory_ctrl #(
  parameter int DEPTH        = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int INIT_PATTERN = 1
) (
  input  logic          clock_in,
  input  logic          reset,
  data_memory_ctrl_if.slave m
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic {
    S_INIT,
    S_READY
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [31:0]   mem_q [DEPTH];

  logic          acc;
  logic [1:0]    ofs;
  logic [IW-1:0] idx;
  logic          is_b, is_h, is_w;
  logic          mis;
  logic [31:0]   rword;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;
  logic [31:0]   ext;

  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [3:0]    wr_be;
  logic [31:0]   wr_data;

  logic          s1_v_q, s1_v_d;
  logic          s1_mis_q, s1_mis_d;
  logic [31:0]   s1_data_q, s1_data_d;
  logic          s2_v_q, s2_v_d;
  logic          s2_mis_q, s2_mis_d;
  logic [31:0]   s2_data_q, s2_data_d;

  // Upper address bits are intentionally ignored (wrap).
  logic unused_addr;
  assign unused_addr = ^m.address;

  assign acc = m.req_valid & (state_q == S_READY);
  assign ofs = m.address[1:0];
  assign idx = m.address[IW+1:2];

  always_comb begin
    is_b = 1'b0;
    is_h = 1'b0;
    is_w = 1'b0;
    unique case (1'b1)
      (m.req_size == 2'd0): is_b = 1'b1;
      (m.req_size == 2'd1): is_h = 1'b1;
      default:              is_w = 1'b1;
    endcase
  end

  assign mis = (is_h & ofs[0]) | (is_w & (|ofs));

  assign rword = mem_q[idx];
  assign rbyte = rword[{ofs, 3'b000} +: 8];
  assign rhalf = ofs[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    ext = 32'd0;
    if (!mis) begin
      if (is_b)
        ext = {{24{~m.req_unsigned & rbyte[7]}}, rbyte};
      else if (is_h)
        ext = {{16{~m.req_unsigned & rhalf[15]}}, rhalf};
      else
        ext = rword;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_be   = 4'h0;
    wr_data = 32'd0;
    unique case (state_q)
      S_INIT: begin
        wr_en   = 1'b1;
        wr_idx  = cnt_q;
        wr_be   = 4'hF;
        wr_data = (INIT_PATTERN != 0) ? 32'(cnt_q) : 32'd0;
        if (cnt_q == IW'(DEPTH - 1))
          state_d = S_READY;
        else
          cnt_d = cnt_q + 1'b1;
      end
      S_READY: begin
        if (acc & m.req_write & ~mis) begin
          wr_en  = 1'b1;
          wr_idx = idx;
          if (is_b) begin
            wr_be   = 4'b0001 << ofs;
            wr_data = {4{m.write_data[7:0]}};
          end else if (is_h) begin
            wr_be   = ofs[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{m.write_data[15:0]}};
          end else begin
            wr_be   = 4'hF;
            wr_data = m.write_data;
          end
        end
      end
      default: ;
    endcase
    if (reset)
      wr_en = 1'b0;
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clock_in) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b])
          mem_q[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  // Data registers hold between responses.
  always_comb begin
    s1_v_d    = acc & ~m.req_write;
    s1_mis_d  = acc & mis;
    s1_data_d = s1_v_d ? ext : s1_data_q;
    s2_v_d    = s1_v_q;
    s2_mis_d  = s1_mis_q;
    s2_data_d = s1_v_q ? s1_data_q : s2_data_q;
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      s1_v_q    <= 1'b0;
      s1_mis_q  <= 1'b0;
      s1_data_q <= 32'd0;
      s2_v_q    <= 1'b0;
      s2_mis_q  <= 1'b0;
      s2_data_q <= 32'd0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_mis_q  <= s1_mis_d;
      s1_data_q <= s1_data_d;
      s2_v_q    <= s2_v_d;
      s2_mis_q  <= s2_mis_d;
      s2_data_q <= s2_data_d;
    end
  end

  assign m.req_ready = (state_q == S_READY);
  assign m.busy      = (state_q == S_INIT);

  if (READ_LATENCY == 2) begin : g_lat2
    assign m.resp_valid = s2_v_q;
    assign m.misaligned = s2_mis_q;
    assign m.read_data  = s2_data_q;
  end else begin : g_lat1
    assign m.resp_valid = s1_v_q;
    assign m.misaligned = s1_mis_q;
    assign m.read_data  = s1_data_q;
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl.
// Two DUTs: READ_LATENCY 1 and 2, DEPTH 32.
module tb_data_memory_ctrl;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_bad;

  data_memory_ctrl_if #(.ADDR_WIDTH(32)) if1 ();
  data_memory_ctrl_if #(.ADDR_WIDTH(32)) if2 ();

  data_memory_ctrl #(
    .DEPTH(32), .ADDR_WIDTH(32),
    .READ_LATENCY(1), .INIT_PATTERN(1)
  ) dut1 (
    .clock_in(clk),
    .reset(reset),
    .m(if1.slave)
  );

  data_memory_ctrl #(
    .DEPTH(32), .ADDR_WIDTH(32),
    .READ_LATENCY(2), .INIT_PATTERN(1)
  ) dut2 (
    .clock_in(clk),
    .reset(reset),
    .m(if2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic req1(
    input logic        w,
    input logic [1:0]  sz,
    input logic        u,
    input logic [31:0] a,
    input logic [31:0] d
  );
    if1.req_valid    = 1'b1;
    if1.req_write    = w;
    if1.req_size     = sz;
    if1.req_unsigned = u;
    if1.address      = a;
    if1.write_data   = d;
    @(posedge clk);
    #1;
    if1.req_valid = 1'b0;
  endtask

  task automatic st(
    input logic [1:0]  sz,
    input logic [31:0] a,
    input logic [31:0] d
  );
    req1(1'b1, sz, 1'b0, a, d);
  endtask

  task automatic ld(
    input string       tag,
    input logic [1:0]  sz,
    input logic        u,
    input logic [31:0] a,
    input logic [31:0] exp,
    input logic        exp_mis
  );
    req1(1'b0, sz, u, a, 32'd0);
    chk({tag, " valid"}, 32'(if1.resp_valid), 32'd1);
    chk({tag, " data"}, if1.read_data, exp);
    chk({tag, " mis"}, 32'(if1.misaligned),
        32'(exp_mis));
  endtask

  task automatic count_init(output int n, output bit stale);
    n = 0;
    stale = 1'b0;
    while (if1.busy && n < 200) begin
      if (if1.req_ready || if1.resp_valid)
        stale = 1'b1;
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  int n_init;
  bit stale;

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b1;
    if1.req_valid    = 1'b0;
    if1.req_write    = 1'b0;
    if1.req_size     = 2'd2;
    if1.req_unsigned = 1'b0;
    if1.address      = 32'd0;
    if1.write_data   = 32'd0;
    if2.req_valid    = 1'b0;
    if2.req_write    = 1'b0;
    if2.req_size     = 2'd2;
    if2.req_unsigned = 1'b0;
    if2.address      = 32'd0;
    if2.write_data   = 32'd0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst ready", 32'(if1.req_ready), 32'd0);
    chk("rst busy", 32'(if1.busy), 32'd1);
    chk("rst rvalid", 32'(if1.resp_valid), 32'd0);
    chk("rst rdata", if1.read_data, 32'd0);
    chk("rst mis", 32'(if1.misaligned), 32'd0);
    reset = 1'b0;

    count_init(n_init, stale);
    chk("init cycles", 32'(n_init), 32'd32);
    chk("init stale", 32'(stale), 32'd0);
    chk("ready after init", 32'(if1.req_ready), 32'd1);

    ld("ld 0x0", 2'd2, 1'b0, 32'h0, 32'h0, 1'b0);
    ld("ld 0x7c", 2'd2, 1'b0, 32'h7C, 32'h1F, 1'b0);
    ld("ld 0x80", 2'd2, 1'b0, 32'h80, 32'h0, 1'b0);

    st(2'd2, 32'h10, 32'h11223344);
    chk("st rvalid", 32'(if1.resp_valid), 32'd0);
    chk("st mis", 32'(if1.misaligned), 32'd0);
    st(2'd0, 32'h11, 32'h000000AA);
    st(2'd1, 32'h12, 32'h00008001);
    ld("lw 0x10", 2'd2, 1'b0, 32'h10, 32'h8001AA44, 1'b0);
    ld("lb 0x11", 2'd0, 1'b0, 32'h11, 32'hFFFFFFAA, 1'b0);
    ld("lbu 0x11", 2'd0, 1'b1, 32'h11, 32'h000000AA, 1'b0);
    ld("lh 0x12", 2'd1, 1'b0, 32'h12, 32'hFFFF8001, 1'b0);
    ld("lhu 0x12", 2'd1, 1'b1, 32'h12, 32'h00008001, 1'b0);
    ld("lb 0x10", 2'd0, 1'b0, 32'h10, 32'h00000044, 1'b0);

    @(posedge clk);
    #1;
    chk("hold rvalid", 32'(if1.resp_valid), 32'd0);
    chk("hold rdata", if1.read_data, 32'h00000044);

    st(2'd2, 32'h6, 32'hDEADBEEF);
    chk("mis st pulse", 32'(if1.misaligned), 32'd1);
    chk("mis st rvalid", 32'(if1.resp_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("mis st once", 32'(if1.misaligned), 32'd0);
    ld("lw 0x4", 2'd2, 1'b0, 32'h4, 32'h1, 1'b0);
    ld("lw 0x5", 2'd2, 1'b0, 32'h5, 32'h0, 1'b1);
    ld("lh 0x11", 2'd1, 1'b0, 32'h11, 32'h0, 1'b1);

    if1.req_valid  = 1'b1;
    if1.req_write  = 1'b1;
    if1.req_size   = 2'd2;
    if1.address    = 32'h20;
    if1.write_data = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    if1.req_write = 1'b0;
    @(posedge clk);
    #1;
    if1.req_valid = 1'b0;
    chk("b2b valid", 32'(if1.resp_valid), 32'd1);
    chk("b2b data", if1.read_data, 32'hCAFEF00D);

    if2.req_valid = 1'b1;
    if2.address   = 32'h4;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      if (i < 2)
        if2.address = 32'(8 + 4 * i);
      else
        if2.req_valid = 1'b0;
      chk($sformatf("lat2 valid c%0d", i),
          32'(if2.resp_valid),
          32'(i >= 1 && i <= 3));
      if (i >= 1 && i <= 3)
        chk($sformatf("lat2 data c%0d", i),
            if2.read_data, 32'(i));
      if (i == 4)
        chk("lat2 hold", if2.read_data, 32'd3);
      @(posedge clk);
      #1;
    end

    st(2'd2, 32'h0, 32'h00000055);
    ld("lw 0x0 pre", 2'd2, 1'b0, 32'h0, 32'h55, 1'b0);
    if1.req_valid = 1'b1;
    if1.req_write = 1'b0;
    if1.address   = 32'h0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    if1.req_valid = 1'b0;
    chk("rst2 rvalid", 32'(if1.resp_valid), 32'd0);
    chk("rst2 rdata", if1.read_data, 32'd0);
    chk("rst2 busy", 32'(if1.busy), 32'd1);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid init busy", 32'(if1.busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    count_init(n_init, stale);
    chk("reinit cycles", 32'(n_init), 32'd32);
    chk("reinit stale", 32'(stale), 32'd0);
    ld("lw 0x0 post", 2'd2, 1'b0, 32'h0, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
# data_memory_ctrl

Parametrised data memory for the single-cycle/multi-cycle CPU datapath, replacing the fixed 32-word, word-only data memory. It adds configurable depth, byte/halfword/word access with sign or zero extension, byte-lane write enables, and a registered read path with a valid/ready handshake. After reset, an init sequencer rewrites every word to a known pattern. The block sits between the ALU address output and the register-file write-back mux.

## Interface
- DEPTH, 32: number of 32-bit words; power of two, from 4 to 4096.
- ADDR_WIDTH, 32: width of the byte address input.
- READ_LATENCY, 1: cycles from request accept to `resp_valid`; legal values are 1 and 2.
- INIT_PATTERN, 1: 0 means every word is initialised to 0; 1 means word i is initialised to i.

- clock_in  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in READY.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = halfword, 2 or 3 = word.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- address  in  ADDR_WIDTH  byte address, little-endian.
- write_data  in  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- resp_valid  out  1  one-cycle pulse: `read_data` is valid.
- read_data  out  32  extended load result; holds its value until the next response.
- misaligned  out  1  one-cycle pulse flagging an accepted misaligned request.
- busy  out  1  high while the init sequence runs.

## Operation
- Word index = `address[log2(DEPTH)+1:2]`. Upper address bits are ignored, so addresses wrap modulo DEPTH*4.
- A request is accepted on an edge where `req_valid & req_ready` is high. There is no backpressure on responses.
- FSM states and transitions:
  - INIT: `busy`=1, `req_ready`=0. A counter walks 0..DEPTH-1, writing one word per cycle with the INIT_PATTERN value. After the word DEPTH-1 is written, the FSM moves to READY.
  - READY: `busy`=0, `req_ready`=1. The FSM stays here until reset.
- Reset, including reset asserted mid-INIT, forces INIT with the counter at 0. Any pending response is dropped.
- Alignment rules:
  - A halfword request with `address[0]`=1 is misaligned.
  - A word request with `address[1:0]`≠0 is misaligned.
  - A byte request is never misaligned.
- Store: only the addressed lanes are written.
  - Byte: lane `address[1:0]` ← `write_data[7:0]`.
  - Halfword: lanes {`address[1]`*2+1, `address[1]`*2} ← `write_data[15:0]`.
  - Word: all four lanes.
  - Misaligned stores write nothing.
- Load: the addressed byte or halfword is extracted from its lane and extended per `req_unsigned`. Word loads ignore `req_unsigned`. A misaligned load returns 0.
- Stores produce no `resp_valid`.
- `misaligned` pulses for both misaligned loads and misaligned stores.

## Timing
- Reset values of outputs:
  - `req_ready`=0, `busy`=1, `resp_valid`=0, `read_data`=0, `misaligned`=0.
- In the first cycle after reset deasserts, the FSM is in INIT.
- INIT lasts exactly DEPTH cycles. `req_ready` rises DEPTH cycles after the first cycle with reset low.
- Store commit: memory is updated at the accepting edge and is visible to a load accepted on the next edge.
- Load read point: a load reads the array state from before its own accepting edge.
- Back-to-back accepts are allowed every cycle; the read pipeline is fully pipelined.
- READY_LATENCY=1: `resp_valid` and `read_data` are registered one edge after accept.
- READY_LATENCY=2: an extra output register stage is added.
- `misaligned` is asserted in the same cycle `resp_valid` would be asserted for that request (READ_LATENCY after accept), for both loads and stores.
- `read_data` is unchanged in cycles where `resp_valid`=0.

## Test plan
- Reset, then init: hold reset 3 cycles, release, count cycles → with DEPTH=32, `busy`=1 and `req_ready`=0 for exactly 32 cycles; word loads of 0x0, 0x7C and 0x80 then return 0x00000000, 0x0000001F and 0x00000000 (wrap-around).
- Byte and halfword stores with extension: word store 0x11223344 @0x10; byte store 0xAA @0x11; halfword store 0x8001 @0x12 → word load @0x10 = 0x8001AA44; signed byte load @0x11 = 0xFFFFFFAA; unsigned byte load @0x11 = 0x000000AA; signed halfword load @0x12 = 0xFFFF8001.
- Latency and back-to-back: READ_LATENCY=2, loads @0x4, 0x8, 0xC on consecutive cycles → `resp_valid` high on 3 consecutive cycles starting 2 cycles after the first accept, with data 1, 2, 3.
- Misalignment: word store 0xDEADBEEF @0x6, then word load @0x4 → `misaligned` pulses once for the store; the load returns 0x00000001; a word load @0x5 returns 0 with `misaligned`=1.
- Reset mid-operation: store 0x55 @0x0, let INIT run 10 cycles after a new reset, then assert reset again → INIT restarts and lasts a full DEPTH cycles from the second release; a load @0x0 afterwards returns 0; no stale `resp_valid` appears.
- Store-then-load ordering: a store of 0xCAFEF00D @0x20 and a load @0x20 accepted on consecutive cycles → the load returns 0xCAFEF00D.
